// File: rtl/hfrisc_soc_pkg.sv
// Shared types and region codes for the HF-RISC SoC bus arbiter.
// The region decode helper maps an address nibble onto the three memory-map windows.
package hfrisc_soc_pkg;

  localparam logic [3:0] BOOT_REGION_DEF   = 4'h0;
  localparam logic [3:0] RAM_REGION_DEF    = 4'h4;
  localparam logic [3:0] PERIPH_REGION_DEF = 4'he;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_DMA   = 2'd1,
    S_FORCE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REG_NONE   = 2'd0,
    REG_BOOT   = 2'd1,
    REG_RAM    = 2'd2,
    REG_PERIPH = 2'd3
  } region_t;

  function automatic region_t decode_region(input logic [3:0] code,
                                            input logic [3:0] boot_code,
                                            input logic [3:0] ram_code,
                                            input logic [3:0] periph_code);
    region_t r;
    if (code == boot_code) begin
      r = REG_BOOT;
    end else if (code == ram_code) begin
      r = REG_RAM;
    end else if (code == periph_code) begin
      r = REG_PERIPH;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/hfrisc_rdata_steer.sv
// Routes registered-latency read data back to whichever master issued the access,
// keeping the core's last completed read visible while it is stalled.
module hfrisc_rdata_steer
  import hfrisc_soc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dma_own_i,
  input  logic        dma_rd_i,
  input  logic [1:0]  region_i,
  input  logic [31:0] boot_data_i,
  input  logic [31:0] ram_data_i,
  input  logic [31:0] periph_data_i,
  output logic [31:0] cpu_data_o,
  output logic [31:0] dma_data_o,
  output logic        dma_rvalid_o
);

  owner_t      owner_dly_q;
  region_t     region_dly_q;
  logic        rvalid_q;
  logic [31:0] hold_q;
  logic [31:0] src_s;

  // Delay-line of who owned the bus and where it pointed; hold tracks the core's last completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_dly_q  <= OWN_CPU;
      region_dly_q <= REG_NONE;
      rvalid_q     <= 1'b0;
      hold_q       <= 32'h0;
    end else begin
      owner_dly_q  <= dma_own_i ? OWN_DMA : OWN_CPU;
      region_dly_q <= region_t'(region_i);
      rvalid_q     <= dma_own_i & dma_rd_i;
      if (owner_dly_q == OWN_CPU) begin
        hold_q <= src_s;
      end
    end
  end

  // Source select for the data returning this cycle; unmapped reads return zero.
  always_comb begin
    src_s = 32'h0;
    case (region_dly_q)
      REG_BOOT:   src_s = boot_data_i;
      REG_RAM:    src_s = ram_data_i;
      REG_PERIPH: src_s = periph_data_i;
      default:    src_s = 32'h0;
    endcase
  end

  // Master-side read outputs, silenced while in reset.
  always_comb begin
    cpu_data_o   = 32'h0;
    dma_data_o   = 32'h0;
    dma_rvalid_o = 1'b0;
    if (!rst_i) begin
      cpu_data_o   = (owner_dly_q == OWN_CPU) ? src_s : hold_q;
      dma_data_o   = (owner_dly_q == OWN_DMA) ? src_s : 32'h0;
      dma_rvalid_o = rvalid_q;
    end else begin
      dma_rvalid_o = 1'b0;
    end
  end

endmodule

// File: rtl/hfrisc_bus_arbiter.sv
// Arbitrates the single SoC memory port between the HF-RISC core and a DMA master.
// DMA wins, but after DMA_MAX_BURST consecutive grants the core is given one cycle.
module hfrisc_bus_arbiter
  import hfrisc_soc_pkg::*;
#(
  parameter logic [7:0] DMA_MAX_BURST = 8'd16,
  parameter logic [3:0] BOOT_REGION   = BOOT_REGION_DEF,
  parameter logic [3:0] RAM_REGION    = RAM_REGION_DEF,
  parameter logic [3:0] PERIPH_REGION = PERIPH_REGION_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_we_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_stall_o,
  input  logic        dma_req_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_data_i,
  input  logic [3:0]  dma_we_i,
  output logic        dma_gnt_o,
  output logic [31:0] dma_data_o,
  output logic        dma_rvalid_o,
  output logic        dma_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_we_o,
  output logic [3:0]  boot_cs_n_o,
  output logic [3:0]  ram_cs_n_o,
  output logic        periph_sel_o,
  output logic        periph_wr_o,
  input  logic [31:0] boot_data_i,
  input  logic [31:0] ram_data_i,
  input  logic [31:0] periph_data_i
);

  arb_state_t  state_q, state_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  owner_t      owner_s;
  region_t     region_s;
  logic [3:0]  own_we_s;

  // Arbitration state and burst length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_CPU;
      burst_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Ownership is decided in-cycle; the grant that reaches the limit schedules a forced core slot.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    owner_s     = OWN_CPU;
    case (state_q)
      S_CPU: begin
        if (dma_req_i) begin
          owner_s     = OWN_DMA;
          burst_cnt_d = 8'd1;
          state_d     = S_DMA;
        end else begin
          burst_cnt_d = 8'd0;
        end
      end
      S_DMA: begin
        if (dma_req_i) begin
          owner_s     = OWN_DMA;
          burst_cnt_d = burst_cnt_q + 8'd1;
          state_d     = ((burst_cnt_q + 8'd1) >= DMA_MAX_BURST) ? S_FORCE : S_DMA;
        end else begin
          burst_cnt_d = 8'd0;
          state_d     = S_CPU;
        end
      end
      S_FORCE: begin
        burst_cnt_d = 8'd0;
        state_d     = S_CPU;
      end
      default: begin
        burst_cnt_d = 8'd0;
        state_d     = S_CPU;
      end
    endcase
    if (rst_i) begin
      owner_s = OWN_CPU;
    end else begin
      owner_s = owner_s;
    end
  end

  assign mem_addr_o  = (owner_s == OWN_DMA) ? dma_addr_i : cpu_addr_i;
  assign mem_data_o  = (owner_s == OWN_DMA) ? dma_data_i : cpu_data_i;
  assign own_we_s    = (owner_s == OWN_DMA) ? dma_we_i : cpu_we_i;
  assign region_s    = decode_region(mem_addr_o[31:28], BOOT_REGION, RAM_REGION, PERIPH_REGION);
  assign dma_gnt_o   = (owner_s == OWN_DMA);
  assign cpu_stall_o = (owner_s == OWN_DMA);
  assign periph_wr_o = periph_sel_o & (|mem_we_o);

  // Chip selects and write gating; boot RAM is read-only and unmapped space is inert.
  always_comb begin
    boot_cs_n_o  = 4'hF;
    ram_cs_n_o   = 4'hF;
    periph_sel_o = 1'b0;
    mem_we_o     = 4'h0;
    dma_err_o    = 1'b0;
    if (!rst_i) begin
      case (region_s)
        REG_BOOT:   boot_cs_n_o = 4'h0;
        REG_RAM: begin
          ram_cs_n_o = 4'h0;
          mem_we_o   = own_we_s;
        end
        REG_PERIPH: begin
          periph_sel_o = 1'b1;
          mem_we_o     = own_we_s;
        end
        default:    mem_we_o = 4'h0;
      endcase
      dma_err_o = (owner_s == OWN_DMA) &&
                  ((region_s == REG_NONE) || ((region_s == REG_BOOT) && (|dma_we_i)));
    end else begin
      mem_we_o = 4'h0;
    end
  end

  hfrisc_rdata_steer u_steer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dma_own_i    (owner_s == OWN_DMA),
    .dma_rd_i     (own_we_s == 4'h0),
    .region_i     (region_s),
    .boot_data_i  (boot_data_i),
    .ram_data_i   (ram_data_i),
    .periph_data_i(periph_data_i),
    .cpu_data_o   (cpu_data_o),
    .dma_data_o   (dma_data_o),
    .dma_rvalid_o (dma_rvalid_o)
  );

endmodule
